router_output_arbiter: RTL
==========================

Name: router_output_arbiter

Overview:
- Per-output-port arbiter and virtual-channel (VC) scheduler for the mesh router.
- Receives channel requests from NUM_IN input controllers and grants one per cycle, round-robin. The grant drives each input controller's channel-clean signal.
- Latches the winning flit into a one-deep even or odd output VC buffer.
- Drains the opposite-polarity buffer to the downstream link, using the same IDLE/ODD/EVEN polarity sequence as the input controllers.

Parameters:
- DATA_WIDTH, 64, flit width.
- NUM_IN, 5, number of requesting input controllers (N, S, E, W, PE). Legal range 2..8.
- PTR_W, 3, round-robin pointer width. Must satisfy 2^PTR_W >= NUM_IN.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_IN  per-input channel request; req[i] high means data_in slice i holds a valid flit.
- data_in  input  NUM_IN*DATA_WIDTH  flattened flits; slice i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- grant  output  NUM_IN  one-hot grant (channel clean) back to the input controllers.
- sendO  output  1  downstream send strobe.
- dataO  output  DATA_WIDTH  downstream flit.
- receiveO  input  1  downstream has a free buffer for the current drain VC.
- polarity  output  1  1 in ODD state, 0 otherwise.

Behaviour:
- Reset (synchronous, dominant at any time, including mid-transfer):
  - state=IDLE; even_valid=odd_valid=0; rr_ptr_even=rr_ptr_odd=0.
  - grant=0, sendO=0, dataO=0, polarity=0.
  - Buffer contents are don't-care.
- State machine (registered):
  - IDLE goes to ODD on the first cycle after reset release.
  - ODD goes to EVEN, and EVEN goes to ODD, unconditionally.
  - No other transitions. An illegal encoding goes to IDLE.
- Arbitration VC and drain VC per state:
  - ODD: arbitrate into odd_buf, drain even_buf.
  - EVEN: arbitrate into even_buf, drain odd_buf.
  - IDLE: no grant, no send.
- Grant (combinational within the cycle):
  - Fires only if the arbitration VC buffer is empty (valid=0) at the start of the cycle.
  - The winner is the first i with req[i]=1, scanning from rr_ptr of that VC upward and wrapping modulo NUM_IN.
  - grant is one-hot or all-zero; never more than one bit.
- Capture at the clock edge when a grant fires:
  - Buffer <= data_in slice of the winner; valid <= 1.
  - rr_ptr of that VC <= (winner+1) mod NUM_IN. Wrap is explicit: winner NUM_IN-1 gives pointer 0.
- No-grant cases: arbitration buffer full, or req=0.
  - grant=0.
  - Pointer and buffer unchanged.
  - Requests are held by the requesters; the arbiter keeps no record of them.
- Drain (combinational):
  - sendO = drain_valid & receiveO.
  - dataO = drain buffer contents when sendO=1, else 0.
  - At the edge, if sendO=1 then drain_valid <= 0.
- Simultaneous events: the arbitration and drain buffers always differ, so a fill and a drain in the same cycle never conflict.
- A buffer filled in one state is drained in the next state at the earliest. Minimum latency from grant to sendO is 1 cycle.
- Each VC keeps its own round-robin pointer; the two VCs never affect each other's fairness.
- req bits for i >= NUM_IN do not exist. The pointer never reaches NUM_IN or above.

Test Plan:
- Reset then idle: rst high for 2 cycles, req=0 → all outputs 0, state IDLE then ODD, polarity toggles 1,0,1… starting the cycle after release.
- Single requester: in ODD, req=5'b00100, slice2=64'hA5 → grant=00100 that cycle; next cycle (EVEN) with receiveO=1 → sendO=1, dataO=64'hA5; rr_ptr_odd=3.
- Round-robin fairness: req=5'b11111 held, receiveO=1 → odd-phase grants cycle 0,1,2,3,4,0; even-phase grants independently cycle 0,1,2,3,4.
- Backpressure: receiveO=0 with odd_buf full → subsequent ODD cycles give grant=0, rr_ptr_odd frozen, sendO=0; raise receiveO → flit drained in the next EVEN cycle, grants resume in the following ODD cycle.
- Pointer wrap: rr_ptr_even=4, req=5'b10001 → grant=10000, then pointer 0 and next even grant 00001.
- Reset mid-operation: both buffers valid, assert rst → next cycle sendO=0, grant=0, valids cleared, pointers 0, state IDLE.

Source files
------------

// File: rtl/router_output_arbiter.sv
// router_output_arbiter: round-robin output arbiter filling even/odd VC buffers and draining the opposite one
module router_output_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_IN     = 5,
    parameter int PTR_W      = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_IN-1:0]            req,
    input  logic [NUM_IN*DATA_WIDTH-1:0] data_in,
    output logic [NUM_IN-1:0]            grant,
    output logic                         sendO,
    output logic [DATA_WIDTH-1:0]        dataO,
    input  logic                         receiveO,
    output logic                         polarity
);
    localparam int IW = PTR_W + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, ODD = 2'd1, EVEN = 2'd2} state_t;

    state_t                state, state_next;
    logic                  even_valid, odd_valid;
    logic [DATA_WIDTH-1:0] even_buf, odd_buf, win_data;
    logic [PTR_W-1:0]      rr_ptr_even, rr_ptr_odd, ptr, win, win_next;
    logic [IW-1:0]         idx;
    logic                  hit, is_odd, is_even, arb_empty, drain_valid, fire;

    assign is_odd      = !rst && state == ODD;
    assign is_even     = !rst && state == EVEN;
    assign ptr         = is_odd ? rr_ptr_odd : rr_ptr_even;
    assign arb_empty   = is_odd ? !odd_valid : is_even && !even_valid;
    assign drain_valid = is_odd ? even_valid : is_even && odd_valid;
    assign fire        = arb_empty && hit;
    assign grant       = fire ? NUM_IN'(1) << win : '0;
    assign sendO       = drain_valid && receiveO;
    assign dataO       = sendO ? (is_odd ? even_buf : odd_buf) : '0;
    assign polarity    = is_odd;
    assign win_next    = (win == PTR_W'(NUM_IN - 1)) ? '0 : win + 1'b1;
    assign win_data    = data_in[win*DATA_WIDTH +: DATA_WIDTH];

    // Polarity sequence: IDLE once after reset, then ODD/EVEN alternating
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = ODD;
            ODD:     state_next = EVEN;
            EVEN:    state_next = ODD;
            default: state_next = IDLE;
        endcase
    end

    // Round-robin scan: first requester at or above the VC pointer, wrapping modulo NUM_IN
    always_comb begin
        win = '0;
        hit = 1'b0;
        idx = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = IW'(ptr) + IW'(k);
            if (idx >= IW'(NUM_IN)) idx = idx - IW'(NUM_IN);
            if (!hit && req[idx[PTR_W-1:0]]) begin
                hit = 1'b1;
                win = idx[PTR_W-1:0];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Valid flags and per-VC pointers; fill and drain never target the same VC in one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            even_valid  <= 1'b0;
            odd_valid   <= 1'b0;
            rr_ptr_even <= '0;
            rr_ptr_odd  <= '0;
        end else begin
            if (fire && is_odd) begin
                odd_valid  <= 1'b1;
                rr_ptr_odd <= win_next;
            end else if (sendO && is_even) begin
                odd_valid  <= 1'b0;
            end
            if (fire && is_even) begin
                even_valid  <= 1'b1;
                rr_ptr_even <= win_next;
            end else if (sendO && is_odd) begin
                even_valid  <= 1'b0;
            end
        end
    end

    // Flit storage; contents only matter while the matching valid flag is set
    always_ff @(posedge clk) begin
        if (fire && is_odd)  odd_buf  <= win_data;
        if (fire && is_even) even_buf <= win_data;
    end
endmodule
